// File: rtl/fg_input_conditioner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fg_input_conditioner_if : pad-side inputs and conditioned outputs bundle |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fg_input_conditioner_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] async_i;
  logic                hold_i;
  logic [CHANNELS-1:0] sync_o;
  logic [CHANNELS-1:0] level_o;
  logic [CHANNELS-1:0] rise_o;
  logic [CHANNELS-1:0] fall_o;
  logic                changed_o;

  modport master (
    output async_i, hold_i,
    input  sync_o, level_o, rise_o, fall_o, changed_o
  );

  modport slave (
    input  async_i, hold_i,
    output sync_o, level_o, rise_o, fall_o, changed_o
  );
endinterface
`default_nettype wire

// File: rtl/fg_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fg_input_conditioner : per-channel synchroniser, debounce, edge pulses   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fg_input_conditioner #(
  parameter int                  CHANNELS        = 4,
  parameter int                  STAGES          = 2,
  parameter int                  DEBOUNCE_CYCLES = 16,
  parameter logic [CHANNELS-1:0] RESET_LEVEL     = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  fg_input_conditioner_if.slave bus
);

  localparam int                 C_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [STAGES-1:0][CHANNELS-1:0]   sync_q;
  logic [CHANNELS-1:0]               sync_last;

  logic [CHANNELS-1:0][C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0]               level_q, level_d;
  logic [CHANNELS-1:0]               rise_q, rise_d;
  logic [CHANNELS-1:0]               fall_q, fall_d;
  logic                              changed_q, changed_d;

  // Stage 0 sits in the lowest slot so the whole chain shifts as one vector.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= {STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], bus.async_i};
    end
  end

  assign sync_last = sync_q[STAGES-1];

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    rise_d    = '0;
    fall_d    = '0;
    if (!bus.hold_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync_last[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] != C_CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + C_CNT_W'(1);
        end else begin
          cnt_d[i]   = '0;
          level_d[i] = sync_last[i];
          rise_d[i]  = sync_last[i];
          fall_d[i]  = ~sync_last[i];
        end
      end
    end
    changed_d = |{rise_d, fall_d};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q     <= '0;
      level_q   <= RESET_LEVEL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign bus.sync_o    = sync_last;
  assign bus.level_o   = level_q;
  assign bus.rise_o    = rise_q;
  assign bus.fall_o    = fall_q;
  assign bus.changed_o = changed_q;

endmodule
`default_nettype wire

// File: doc/fg_input_conditioner.md
# fg_input_conditioner

Multi-channel input conditioner for the function generator's external control inputs, such as buttons, trigger and mode pins. For each channel it synchronises an asynchronous input into `clk_i` through a configurable flip-flop chain and filters it with a per-channel debounce counter. It also emits single-cycle rise and fall pulses on the debounced level. It sits between the pad inputs and the control FSM, which consumes only the debounced levels and the edge pulses.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `STAGES`, 2: synchroniser flip-flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before the debounced level changes (≥1; 1 = no filtering, one-cycle register only).
- `RESET_LEVEL`, {CHANNELS{1'b0}}: per-channel reset value of every synchroniser stage and of `level_o`.

- `clk_i`  in  1  single system clock, rising edge.
- `rstn_i`  in  1  reset; asynchronous, active-low.
- `async_i`  in  CHANNELS  raw asynchronous inputs.
- `hold_i`  in  1  synchronous freeze of the debounce stage (synchroniser keeps running).
- `sync_o`  out  CHANNELS  synchronised, unfiltered level (last synchroniser stage).
- `level_o`  out  CHANNELS  debounced level.
- `rise_o`  out  CHANNELS  one-cycle pulse when `level_o[i]` goes 0→1.
- `fall_o`  out  CHANNELS  one-cycle pulse when `level_o[i]` goes 1→0.
- `changed_o`  out  1  OR of all `rise_o` / `fall_o` bits, same cycle.

## Operation
- Reset (async, `rstn_i`=0): all synchroniser stages and `level_o` take `RESET_LEVEL`. Debounce counters, `rise_o`, `fall_o` and `changed_o` go to 0. Unlike the earlier synchroniser, every stage is reset, not only the first.
- Synchroniser: stage 0 samples `async_i[i]` and stage k samples stage k-1. `sync_o` is stage `STAGES-1`.
- Debounce, per channel, counter width `$clog2(DEBOUNCE_CYCLES)` (min 1 bit):
  - `sync_o[i] == level_o[i]`: counter clears to 0.
  - `sync_o[i] != level_o[i]` and counter < `DEBOUNCE_CYCLES-1`: counter increments.
  - `sync_o[i] != level_o[i]` and counter == `DEBOUNCE_CYCLES-1`: `level_o[i]` ← `sync_o[i]`, counter ← 0, and the matching `rise_o[i]` / `fall_o[i]` is asserted on the same edge.
- Pulses are registered and high for exactly one cycle. They are 0 on every edge where no level update occurs.
- `hold_i`=1: counters and `level_o` hold their values and all pulses are 0. `sync_o` continues to track. On `hold_i` falling, counting resumes from the held count.
- Channels are fully independent. Simultaneous updates on several channels produce simultaneous pulses and a single `changed_o` cycle.
- A bounce (`sync_o` returning to `level_o` before the count completes) clears the counter. The counter never wraps.

## Timing
- `async_i` first captured at edge N → `sync_o` changes after edge N+STAGES-1.
- With `sync_o` stable from edge M, `level_o`, the pulse and `changed_o` update after edge M+DEBOUNCE_CYCLES. The pulse deasserts after edge M+DEBOUNCE_CYCLES+1.
- Total input-to-level latency: STAGES-1+DEBOUNCE_CYCLES edges after first capture, extended by any cycles spent in hold.
- Minimum accepted pulse width on `async_i`: DEBOUNCE_CYCLES cycles. Shorter pulses are rejected.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use CHANNELS=4, STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0.
- **Reset:** drive `async_i`=4'hF, then assert `rstn_i`=0 between edges → all outputs 0 immediately. Release reset, hold `async_i`=4'hF → `sync_o`=F after 2 edges, `level_o`=F and `rise_o`=F after 4 more edges, then `rise_o`=0.
- **Clean step:** `async_i[0]` 0→1 captured at edge 10 → `sync_o[0]`=1 after edge 11. `level_o[0]`=1, `rise_o[0]`=1 and `changed_o`=1 after edge 15. `rise_o[0]`=0 after edge 16.
- **Glitch rejection:** `async_i[1]` high for 3 cycles → `sync_o[1]` pulses for 3 cycles. `level_o[1]`, `rise_o[1]` and `changed_o` stay 0 throughout.
- **Bounce:** `async_i[2]` pattern 1,1,0,1,1,1,1,… → exactly one `rise_o[2]`, 4 edges after `sync_o[2]` last went high. No `fall_o[2]`.
- **Simultaneous edges:** `level_o`=4'h8; in the same cycle `async_i[0]` rises and `async_i[3]` falls → `rise_o`=4'h1, `fall_o`=4'h8 and `changed_o`=1 in one cycle. `level_o`=4'h1.
- **Hold:** step `async_i[0]`, assert `hold_i` for 5 cycles after the count reaches 2 → `level_o[0]` is delayed by exactly 5 cycles versus the clean step. No pulses while `hold_i`=1.
